// File: rtl/seg7_scan_reader.sv
// Passive monitor for a multiplexed 4-digit active-low 7-segment bus; rebuilds the shown hex value.
// Optional SEG7_ERR_EN enables illegal-pattern pulse and saturating error counter.
module seg7_scan_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           seg,
    input  logic [3:0]           an,
    output logic [15:0]          value,
    output logic [3:0]           digit_valid,
    output logic [15:0]          frame_value,
    output logic                 frame_valid,
    output logic                 pattern_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t           state_q, state_d;
    logic [10:0]      s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      value_q, value_d;
    logic [3:0]       dv_q, dv_d;
    logic [3:0]       mask_q, mask_d;
    logic [15:0]      fvalue_q, fvalue_d;
    logic             fvalid_q, fvalid_d;
    logic             changed, single, capture, legal;
    logic [1:0]       idx;
    logic [3:0]       nib;

    // Active-high g..a pattern -> {legal, nibble}
    function automatic logic [4:0] decode(input logic [6:0] pat);
        case (pat)
            7'h3F: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;
            7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;
            7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;
            7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;
            7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        s_d     = {an, seg};
        changed = (s_d != s_q);
        single  = 1'b1;
        idx     = 2'd0;
        case (s_d[10:7])
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: single = 1'b0;
        endcase
        {legal, nib} = decode(~s_d[6:0]);

        if (changed)             cnt_d = CNT_W'(1);
        else if (cnt_q >= CNT_MAX) cnt_d = CNT_MAX;
        else                     cnt_d = cnt_q + CNT_W'(1);

        // FSM tracks what s_q will hold after this edge
        capture = 1'b0;
        if (!single)                  state_d = IDLE;
        else if (changed)             state_d = SETTLE;
        else if (state_q == HELD)     state_d = HELD;
        else if (cnt_d == CNT_MAX) begin
            state_d = HELD;
            capture = (state_q == SETTLE);
        end else                      state_d = SETTLE;

        value_d  = value_q;
        dv_d     = dv_q;
        mask_d   = mask_q;
        fvalue_d = fvalue_q;
        fvalid_d = 1'b0;
        if (capture && legal) begin
            value_d[idx*4 +: 4] = nib;
            dv_d[idx]           = 1'b1;
            mask_d[idx]         = 1'b1;
            if (mask_d == 4'hF) begin
                fvalue_d = value_d;
                fvalid_d = 1'b1;
                mask_d   = 4'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s_q      <= '0;
            cnt_q    <= '0;
            value_q  <= '0;
            dv_q     <= '0;
            mask_q   <= '0;
            fvalue_q <= '0;
            fvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            value_q  <= value_d;
            dv_q     <= dv_d;
            mask_q   <= mask_d;
            fvalue_q <= fvalue_d;
            fvalid_q <= fvalid_d;
        end
    end

    assign value       = value_q;
    assign digit_valid = dv_q;
    assign frame_value = fvalue_q;
    assign frame_valid = fvalid_q;

`ifdef SEG7_ERR_EN
    logic                 perr_q, perr_d;
    logic [ERR_CNT_W-1:0] errc_q, errc_d;

    always_comb begin
        perr_d = capture && !legal;
        errc_d = errc_q;
        if (perr_d && (errc_q != '1)) errc_d = errc_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
            errc_q <= '0;
        end else begin
            perr_q <= perr_d;
            errc_q <= errc_d;
        end
    end

    assign pattern_err = perr_q;
    assign err_count   = errc_q;
`else
    assign pattern_err = 1'b0;
    assign err_count   = '0;
`endif

endmodule
